// File: rtl/reg_addr_sel_sb.sv
// reg_addr_sel_sb: Reg2Loc read-address decode into a one-entry decode slot, guarded by a
// pending-write (RAW) scoreboard. Optional stall counter enabled by REG_ADDR_SEL_SB_STALL_CNT_EN.
module reg_addr_sel_sb #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31,
  parameter int INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               reg2loc,
  input  logic               use_rs1,
  input  logic               use_rs2,
  input  logic               writes_reg,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  rd_addr1,
  output logic [ADDR_W-1:0]  rd_addr2,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               wr_en,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_addr
`ifdef REG_ADDR_SEL_SB_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [ADDR_W-1:0]   sel1_s;
  logic [ADDR_W-1:0]   sel2_s;
  logic [ADDR_W-1:0]   dst_s;
  logic                busy1_s;
  logic                busy2_s;
  logic                hazard_s;
  logic                accept_s;
  logic                issue_s;
  logic                unused_s;

  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   rd_addr1_q, rd_addr1_d;
  logic [ADDR_W-1:0]   rd_addr2_q, rd_addr2_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  // A source stalls on a live pending bit (unless written back this cycle) or on the unissued slot writer.
  function automatic logic src_busy(
    input logic                use_src,
    input logic [ADDR_W-1:0]   addr,
    input logic [NUM_REGS-1:0] pend,
    input logic                wbv,
    input logic [ADDR_W-1:0]   wba,
    input logic                slot_v,
    input logic                slot_we,
    input logic [ADDR_W-1:0]   slot_wa
  );
    logic pend_live;
    logic slot_hit;
    pend_live = pend[addr] & ~(wbv & (wba == addr));
    slot_hit  = slot_v & slot_we & (slot_wa == addr);
    return use_src & (addr != ZERO_A) & (pend_live | slot_hit);
  endfunction

  assign sel1_s   = ADDR_W'(instr[9:5]);
  assign dst_s    = ADDR_W'(instr[4:0]);
  assign sel2_s   = reg2loc ? ADDR_W'(instr[4:0]) : ADDR_W'(instr[20:16]);
  assign unused_s = ^{instr[INSTR_W-1:21], instr[15:10]};

  assign busy1_s  = src_busy(use_rs1, sel1_s, pending_q, wb_valid, wb_addr,
                             out_valid_q, wr_en_q, wr_addr_q);
  assign busy2_s  = src_busy(use_rs2, sel2_s, pending_q, wb_valid, wb_addr,
                             out_valid_q, wr_en_q, wr_addr_q);
  assign hazard_s = busy1_s | busy2_s;

  assign in_ready = ~reset & ~flush & ~hazard_s & (~out_valid_q | out_ready);
  assign accept_s = in_valid & in_ready;
  assign issue_s  = out_valid_q & out_ready & ~flush;

  // Decode slot next state: flush drops the slot, accept reloads it, a bare issue empties it.
  always_comb begin
    out_valid_d = out_valid_q;
    rd_addr1_d  = rd_addr1_q;
    rd_addr2_d  = rd_addr2_q;
    wr_addr_d   = wr_addr_q;
    wr_en_d     = wr_en_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
      rd_addr1_d  = sel1_s;
      rd_addr2_d  = sel2_s;
      wr_addr_d   = dst_s;
      wr_en_d     = writes_reg & (dst_s != ZERO_A);
    end else if (issue_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Scoreboard: clear on writeback first so a same-edge set of the same index wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid && (wb_addr != ZERO_A)) begin
      pending_d[wb_addr] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (issue_s && wr_en_q) begin
      pending_d[wr_addr_q] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // Slot and scoreboard registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rd_addr1_q  <= {ADDR_W{1'b0}};
      rd_addr2_q  <= {ADDR_W{1'b0}};
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_en_q     <= 1'b0;
      pending_q   <= {NUM_REGS{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      rd_addr1_q  <= rd_addr1_d;
      rd_addr2_q  <= rd_addr2_d;
      wr_addr_q   <= wr_addr_d;
      wr_en_q     <= wr_en_d;
      pending_q   <= pending_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rd_addr1  = rd_addr1_q;
  assign rd_addr2  = rd_addr2_q;
  assign wr_addr   = wr_addr_q;
  assign wr_en     = wr_en_q;

`ifdef REG_ADDR_SEL_SB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where an otherwise acceptable instruction is held by a hazard.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && hazard_s && (!out_valid_q || out_ready) && !flush &&
        (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_reg_addr_sel_sb.sv
// Scoreboard bench for reg_addr_sel_sb: directed scenarios then random traffic against
// a behavioural model of the decode slot and pending-register set.
module tb_reg_addr_sel_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        reg2loc;
  logic        use_rs1;
  logic        use_rs2;
  logic        writes_reg;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [4:0]  wr_addr;
  logic        wr_en;
  logic        wb_valid;
  logic [4:0]  wb_addr;
`ifdef REG_ADDR_SEL_SB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  reg_addr_sel_sb dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .reg2loc(reg2loc), .use_rs1(use_rs1), .use_rs2(use_rs2), .writes_reg(writes_reg),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .wr_addr(wr_addr), .wr_en(wr_en), .wb_valid(wb_valid),
    .wb_addr(wb_addr)
`ifdef REG_ADDR_SEL_SB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] wa;
    logic       we;
  } exp_t;

  exp_t        q[$];
  exp_t        m_slot;
  bit          m_sv;
  bit [31:0]   m_pend;
  logic [31:0] m_cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd);
    return {11'd0, rm, 6'd0, rn, rd};
  endfunction

  // Reference rule: a used, non-zero source is busy while some older writer has not yet written it back.
  function automatic bit m_busy(input bit u, input logic [4:0] a, input bit wbv, input logic [4:0] wba);
    if (!u || a == 5'd31) return 1'b0;
    if (m_pend[a] && !(wbv && wba == a)) return 1'b1;
    return m_sv && m_slot.we && (m_slot.wa == a);
  endfunction

  task automatic step(input bit iv, input logic [31:0] ins, input bit r2l, input bit u1,
                      input bit u2, input bit wr, input bit fl, input bit ordy,
                      input bit wbv, input logic [4:0] wba, input bit rst);
    bit   haz;
    bit   exp_rdy;
    bit   acc;
    bit   iss;
    exp_t e;
    @(negedge clk);
    in_valid = iv; instr = ins; reg2loc = r2l; use_rs1 = u1; use_rs2 = u2;
    writes_reg = wr; flush = fl; out_ready = ordy; wb_valid = wbv; wb_addr = wba; reset = rst;
    #2;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_sv});
`ifdef REG_ADDR_SEL_SB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_cnt);
`endif
    e.r1 = ins[9:5];
    e.r2 = r2l ? ins[4:0] : ins[20:16];
    e.wa = ins[4:0];
    e.we = wr && (ins[4:0] != 5'd31);
    haz = m_busy(u1, e.r1, wbv, wba) || m_busy(u2, e.r2, wbv, wba);
    exp_rdy = !rst && !fl && !haz && (!m_sv || ordy);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = iv && exp_rdy;
    iss = m_sv && ordy && !fl;
    if (rst) begin
      m_pend = '0; m_sv = 1'b0; m_cnt = 32'd0; q.delete();
    end else begin
      if (iv && haz && (!m_sv || ordy) && !fl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (wbv && wba != 5'd31) m_pend[wba] = 1'b0;
      if (iss && m_slot.we) m_pend[m_slot.wa] = 1'b1;
      if (fl) m_sv = 1'b0;
      else if (acc) begin m_sv = 1'b1; m_slot = e; q.push_back(e); end
      else if (iss) m_sv = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'd0, 0, 0, 0, 0, 0, 1, 0, 5'd0, 0);
  endtask

  // Monitor: whenever the slot is presented, compare it to the oldest expected entry.
  always begin
    @(negedge clk);
    #3;
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL slot_queue: out_valid=1 got no expected entry at %0t", $time);
      end else begin
        chk("rd_addr1", {27'd0, rd_addr1}, {27'd0, q[0].r1});
        chk("rd_addr2", {27'd0, rd_addr2}, {27'd0, q[0].r2});
        chk("wr_addr",  {27'd0, wr_addr},  {27'd0, q[0].wa});
        chk("wr_en",    {31'd0, wr_en},    {31'd0, q[0].we});
        if (out_ready || flush) void'(q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr = 32'd0; reg2loc = 1'b0; use_rs1 = 1'b0;
    use_rs2 = 1'b0; writes_reg = 1'b0; flush = 1'b0; out_ready = 1'b0; wb_valid = 1'b0;
    wb_addr = 5'd0;
    m_pend = '0; m_sv = 1'b0; m_cnt = 32'd0; m_slot = '0;

    step(0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 1);
    step(0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 1);
    idle(1);
    chk("rst_rd_addr1", {27'd0, rd_addr1}, 32'd0);
    chk("rst_rd_addr2", {27'd0, rd_addr2}, 32'd0);
    chk("rst_wr_addr",  {27'd0, wr_addr},  32'd0);
    chk("rst_wr_en",    {31'd0, wr_en},    32'd0);

    // Reg2Loc select: Rn=3, Rm=0, Rt=31.
    step(1, mk(5'd3, 5'd0, 5'd31), 0, 0, 0, 0, 0, 1, 0, 5'd0, 0);
    step(1, mk(5'd3, 5'd0, 5'd31), 1, 0, 0, 0, 0, 1, 0, 5'd0, 0);
    idle(2);

    // RAW stall on X5 until its writeback, accepted in the writeback cycle.
    step(1, mk(5'd0, 5'd0, 5'd5), 0, 0, 0, 1, 0, 1, 0, 5'd0, 0);
    for (int i = 0; i < 4; i++) step(1, mk(5'd5, 5'd0, 5'd1), 0, 1, 0, 0, 0, 1, 0, 5'd0, 0);
    step(1, mk(5'd5, 5'd0, 5'd1), 0, 1, 0, 0, 0, 1, 1, 5'd5, 0);
    idle(2);

    // Zero register: writer of X31 never creates a hazard.
    step(1, mk(5'd0, 5'd0, 5'd31), 0, 0, 0, 1, 0, 1, 0, 5'd0, 0);
    step(1, mk(5'd31, 5'd0, 5'd2), 0, 1, 0, 0, 0, 1, 0, 5'd0, 0);
    idle(2);

    // Backpressure for three cycles, then issue and accept on the same edge.
    step(1, mk(5'd1, 5'd2, 5'd3), 0, 0, 0, 0, 0, 1, 0, 5'd0, 0);
    for (int i = 0; i < 3; i++) step(1, mk(5'd4, 5'd6, 5'd8), 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
    step(1, mk(5'd4, 5'd6, 5'd8), 0, 0, 0, 0, 0, 1, 0, 5'd0, 0);
    idle(2);

    // Flushed writer of X7 leaves no pending bit behind.
    step(1, mk(5'd0, 5'd0, 5'd7), 0, 0, 0, 1, 0, 0, 0, 5'd0, 0);
    step(0, 32'd0, 0, 0, 0, 0, 1, 1, 0, 5'd0, 0);
    step(1, mk(5'd7, 5'd7, 5'd9), 1, 1, 1, 0, 0, 1, 0, 5'd0, 0);
    idle(2);

    // Reset in the middle of a stall clears the scoreboard.
    step(1, mk(5'd0, 5'd0, 5'd5), 0, 0, 0, 1, 0, 1, 0, 5'd0, 0);
    for (int i = 0; i < 3; i++) step(1, mk(5'd5, 5'd0, 5'd1), 0, 1, 0, 0, 0, 1, 0, 5'd0, 0);
    step(1, mk(5'd5, 5'd0, 5'd1), 0, 1, 0, 0, 0, 1, 0, 5'd0, 1);
    step(1, mk(5'd5, 5'd0, 5'd1), 0, 1, 0, 0, 0, 1, 0, 5'd0, 0);
    idle(2);

    // Random traffic over a small register subset to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      logic [4:0]  rn;
      logic [4:0]  rm;
      logic [4:0]  rd;
      logic [4:0]  wba;
      rn  = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      rm  = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      rd  = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      wba = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      ins = $urandom;
      ins[9:5] = rn;
      ins[20:16] = rm;
      ins[4:0] = rd;
      step($urandom_range(0, 3) != 0, ins, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, wba, $urandom_range(0, 299) == 0);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_addr_sel_sb.md
Name: reg_addr_sel_sb

Overview:
- Parametrised successor to the Reg2Loc read-address mux.
- Decodes the read-register addresses and the destination address from an instruction word. Selects the second read address by Reg2Loc.
- Registers the result into a one-entry decode pipeline slot with a valid/ready handshake.
- Holds a pending-write scoreboard that stalls the instruction on RAW hazards until writeback clears them.
- Sits between instruction fetch and the register file / ID-EX boundary.

Parameters:
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers; scoreboard depth.
- ZERO_REG, 31, hardwired-zero register index; never marked pending, never causes a hazard.
- INSTR_W, 32, instruction word width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction available.
- in_ready  out  1  instruction accepted this cycle when in_valid&in_ready.
- instr  in  INSTR_W  instruction; fields: Rn=[9:5], Rm=[20:16], Rt/Rd=[4:0].
- reg2loc  in  1  0: rd_addr2=Rm [20:16]; 1: rd_addr2=Rt [4:0].
- use_rs1  in  1  instruction reads rd_addr1.
- use_rs2  in  1  instruction reads rd_addr2.
- writes_reg  in  1  instruction writes Rd [4:0].
- flush  in  1  discard the slot contents.
- out_valid  out  1  slot holds an instruction.
- out_ready  in  1  downstream accepts the slot.
- rd_addr1  out  ADDR_W  registered Rn.
- rd_addr2  out  ADDR_W  registered Reg2Loc-selected address.
- wr_addr  out  ADDR_W  registered Rd.
- wr_en  out  1  registered writes_reg (forced 0 when Rd==ZERO_REG).
- wb_valid  in  1  writeback completes this cycle.
- wb_addr  in  ADDR_W  writeback register index.

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0; rd_addr1, rd_addr2, wr_addr = 0; wr_en=0.
  - All scoreboard bits cleared.
  - in_ready=0 during the reset cycle.
- Address select is combinational on the input side:
  - sel2 = reg2loc ? instr[4:0] : instr[20:16].
  - sel1 = instr[9:5].
  - dst = instr[4:0].
- Hazard (combinational):
  - A source is busy if its use_rsN bit is set, its address != ZERO_REG, and either of these holds:
    - (pending[addr] & !(wb_valid & wb_addr==addr)); writeback in the same cycle bypasses the stall.
    - (out_valid & wr_en & wr_addr==addr); the slot instruction is not yet issued.
  - hazard = busy1 | busy2.
- Handshake:
  - in_ready = !reset & !flush & !hazard & (!out_valid | out_ready).
  - Accept loads the slot on the next edge: out_valid=1 and address fields latched. Latency is 1 cycle from accept to out_valid.
  - Slot contents are held stable while out_valid & !out_ready.
  - Issue = out_valid & out_ready & !flush.
  - When issue occurs with no new accept, out_valid goes to 0.
- Scoreboard:
  - On issue with wr_en=1, set pending[wr_addr].
  - On wb_valid, clear pending[wb_addr].
  - Same-edge set and clear of the same index: set wins.
  - wb_valid for a non-pending index: no effect.
  - wb_addr==ZERO_REG: ignored.
- Flush:
  - Next edge out_valid=0; the slot instruction is never issued and sets no pending bit.
  - Scoreboard is preserved; writeback still clears bits.
  - flush has priority over out_ready and in_valid.
- Back-to-back: a dependent instruction following a writer stalls at least until the writer's wb_valid cycle. With wb bypass it is accepted in the wb cycle, giving out_valid the next edge.

Optional Feature:
- REG_ADDR_SEL_SB_STALL_CNT_EN:
  - When defined, adds output stall_cnt[31:0].
  - stall_cnt increments each cycle with in_valid & hazard & (!out_valid | out_ready) & !flush.
  - Saturates at 0xFFFFFFFF; reset to 0.
  - When undefined, the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reg2Loc select: instr Rm=0, Rt=31, Rn=3, reg2loc=0, then reg2loc=1, out_ready=1 -> rd_addr2 = 0 then 31; rd_addr1=3; one cycle latency each.
- RAW stall: issue writer Rd=5 (writes_reg=1), then reader Rn=5 use_rs1=1 -> in_ready=0 until wb_valid with wb_addr=5. Reader is accepted in that wb cycle and out_valid rises the next edge.
- Zero register: writer Rd=31, then reader Rn=31 -> wr_en=0, no stall, pending[31] stays 0.
- Backpressure: out_ready=0 for 3 cycles with slot valid -> outputs stable, in_ready=0; out_ready=1 -> issue and next accept on the same edge.
- Flush: slot holds writer Rd=7, flush=1 -> out_valid=0 next cycle. A subsequent reader of X7 is not stalled (pending[7]=0).
- Reset mid-stall: pending[5]=1, reader stalled, reset for 1 cycle -> out_valid=0, scoreboard clear, reader accepted the first cycle after reset.
